// File: rtl/snes_cmd_pkg.sv
// Shared constants for the SNES command scheduler: command codes, button bit positions, FSM states.
// No logic; imported by the scheduler and its FIFO.
// Backpressure: not applicable.
package snes_cmd_pkg;

    localparam logic [2:0] CMD_LEFT      = 3'd0;
    localparam logic [2:0] CMD_RIGHT     = 3'd1;
    localparam logic [2:0] CMD_SOFT_DROP = 3'd2;
    localparam logic [2:0] CMD_HARD_DROP = 3'd3;
    localparam logic [2:0] CMD_ROT_CW    = 3'd4;
    localparam logic [2:0] CMD_ROT_CCW   = 3'd5;
    localparam logic [2:0] CMD_PAUSE     = 3'd6;
    localparam logic [2:0] CMD_RESTART   = 3'd7;

    localparam int BTN_B      = 14;
    localparam int BTN_Y      = 13;
    localparam int BTN_SELECT = 12;
    localparam int BTN_START  = 11;
    localparam int BTN_UP     = 10;
    localparam int BTN_DOWN   = 9;
    localparam int BTN_LEFT   = 8;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 6;
    localparam int BTN_X      = 5;
    localparam int BTN_L      = 4;
    localparam int BTN_R      = 3;

    localparam int NUM_CMDS = 8;
    localparam int NUM_DAS  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_t;

    // Priority encoder: lowest-numbered set bit wins.
    function automatic logic [2:0] lowest_set(input logic [NUM_CMDS-1:0] m);
        lowest_set = 3'd0;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with a registered-storage head output.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             pop_ok;
    logic             push_ok;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == FULL_CNT);
    assign o_head  = mem_q[rd_q];
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = i_push_dat;
            wr_d        = wr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snes_cmd_sched.sv
// Turns SNES poll snapshots into game commands: press edges, DAS repeats, priority serialisation.
// Latency: strobe at t -> first push at t+1 -> o_cmd_valid at t+2 (empty FIFO), 1 push per cycle.
// Backpressure: i_cmd_ready stalls the FIFO head; events hitting a full FIFO are dropped with o_cmd_ovf.
module snes_cmd_sched
    import snes_cmd_pkg::*;
#(
    parameter int DAS_DELAY  = 16,
    parameter int DAS_RATE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [14:0] i_btn_state,
    input  logic        i_btn_state_en,
    output logic        o_cmd_valid,
    output logic [2:0]  o_cmd,
    input  logic        i_cmd_ready,
    output logic        o_cmd_ovf
);

    localparam logic [7:0] DLY    = 8'(DAS_DELAY);
    localparam logic [7:0] RELOAD = 8'(DAS_DELAY - DAS_RATE);

    logic [NUM_CMDS-1:0] cur;
    logic [NUM_CMDS-1:0] prev_q, prev_d;
    logic [NUM_CMDS-1:0] mask_q, mask_d;
    logic [NUM_CMDS-1:0] ev;
    logic [NUM_CMDS-1:0] clr;
    logic [7:0]          cnt_q [NUM_DAS];
    logic [7:0]          cnt_d [NUM_DAS];
    logic [7:0]          cnt_inc;
    sched_state_t        state_q, state_d;
    logic                ovf_q, ovf_d;
    logic                lr_hold;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                drop;
    logic [2:0]          push_code;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2:0]          fifo_head;
    logic                unused_btn;

    // Mapped bit position equals command code.
    assign cur = {i_btn_state[BTN_SELECT], i_btn_state[BTN_START], i_btn_state[BTN_B],
                  i_btn_state[BTN_A], i_btn_state[BTN_UP], i_btn_state[BTN_DOWN],
                  i_btn_state[BTN_RIGHT], i_btn_state[BTN_LEFT]};
    assign unused_btn = ^{i_btn_state[BTN_Y], i_btn_state[BTN_X], i_btn_state[BTN_L],
                          i_btn_state[BTN_R], i_btn_state[2:0]};

    assign o_cmd_valid = !fifo_empty;
    assign o_cmd       = fifo_head;
    assign o_cmd_ovf   = ovf_q;

    always_comb begin
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        cnt_inc = '0;
        ev      = '0;
        lr_hold = cur[CMD_LEFT] && cur[CMD_RIGHT];
        if (i_btn_state_en) begin
            prev_d = cur;
            ev     = cur & ~prev_q;
            // DAS counter index i drives command code i (LEFT, RIGHT, SOFT_DROP).
            for (int i = 0; i < NUM_DAS; i++) begin
                cnt_inc = cnt_q[i] + 8'd1;
                if (!cur[i] || !prev_q[i]) begin
                    cnt_d[i] = '0;
                end else if (lr_hold && i < 2) begin
                    cnt_d[i] = cnt_q[i];
                end else if (cnt_q[i] < DLY) begin
                    if (cnt_inc == DLY) begin
                        ev[i]    = 1'b1;
                        cnt_d[i] = RELOAD;
                    end else begin
                        cnt_d[i] = cnt_inc;
                    end
                end
            end
        end
    end

    always_comb begin
        push_req  = 1'b0;
        push_code = lowest_set(mask_q);
        pop       = o_cmd_valid && i_cmd_ready;
        case (state_q)
            ST_IDLE:  push_req = 1'b0;
            ST_ISSUE: push_req = 1'b1;
            default:  push_req = 1'b0;
        endcase
        drop    = push_req && fifo_full && !pop;
        push    = push_req && !drop;
        clr     = push_req ? (8'b1 << push_code) : 8'b0;
        mask_d  = (mask_q & ~clr) | ev;
        state_d = (mask_d != '0) ? ST_ISSUE : ST_IDLE;
        ovf_d   = drop;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '{default: '0};
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    cmd_fifo #(
        .WIDTH (3),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (push),
        .i_push_dat (push_code),
        .i_pop      (pop),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty),
        .o_head     (fifo_head)
    );

endmodule
